// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl -- coefficient manager and sequencer for the pipelined
// direct-form FIR.
//
// A new coefficient set streams in (valid/ready, tap 0 first) into a shadow
// bank. A commit arms a swap that is applied to the active bank on the next
// sample strobe, so the filter never sees a mixed set. After the swap, flush
// is held high for FLUSH_SAMPLES strobes while the filter pipeline drains.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   sample_stb   one-cycle pulse per ADC sample (also the filter clock enable)
//   load_start   begins or restarts a coefficient load
//   coef_valid   stream valid
//   coef_data    signed coefficient, tap 0 .. TAP_LEN-1
//   coef_ready   stream ready (registered)
//   commit       request swap of shadow bank into active bank
//   fir_coef     active bank, tap i at [i*COEF_WIDTH +: COEF_WIDTH]
//   flush        filter output invalid after a swap
//   busy         controller not idle
//   armed        complete set waiting in shadow bank (ARMED or PENDING)
//   coef_gen     swap counter, wraps 255 -> 0
//   err_unexp    sticky: beat presented while not ready
module fir_coef_ctrl #(
  parameter int TAP_LEN       = 63,
  parameter int COEF_WIDTH    = 16,
  parameter int FLUSH_SAMPLES = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_stb,
  input  logic                          load_start,
  input  logic                          coef_valid,
  input  logic [COEF_WIDTH-1:0]         coef_data,
  output logic                          coef_ready,
  input  logic                          commit,
  output logic [TAP_LEN*COEF_WIDTH-1:0] fir_coef,
  output logic                          flush,
  output logic                          busy,
  output logic                          armed,
  output logic [7:0]                    coef_gen,
  output logic                          err_unexp
);

  localparam int TAP_W = (TAP_LEN > 1) ? $clog2(TAP_LEN) : 1;
  localparam int FCW   = $clog2(FLUSH_SAMPLES + 1);

  localparam logic [TAP_W-1:0]      LAST_TAP = TAP_W'(TAP_LEN - 1);
  localparam logic [FCW-1:0]        FLUSH_N  = FCW'(FLUSH_SAMPLES);
  // Largest positive Q value: unity gain on tap 0 gives a pass-through filter.
  localparam logic [COEF_WIDTH-1:0] UNITY    = {1'b0, {(COEF_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARMED,
    PENDING,
    FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [TAP_W-1:0]      tap_cnt_q, tap_cnt_d;
  logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [7:0]            gen_q, gen_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  shadow_we;
  logic                  swap;

  logic [COEF_WIDTH-1:0] shadow_q [TAP_LEN];
  logic [COEF_WIDTH-1:0] active_q [TAP_LEN];

  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    flush_cnt_d = flush_cnt_q;
    gen_d       = gen_q;
    err_d       = err_q;
    shadow_we   = 1'b0;
    swap        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = LOAD;
          tap_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      LOAD: begin
        // A restart drops any beat offered in the same cycle.
        if (load_start) begin
          tap_cnt_d = '0;
          err_d     = 1'b0;
        end else if (coef_valid && ready_q) begin
          shadow_we = 1'b1;
          if (tap_cnt_q == LAST_TAP) begin
            state_d   = ARMED;
            tap_cnt_d = '0;
          end else begin
            tap_cnt_d = tap_cnt_q + 1'b1;
          end
        end
      end
      ARMED: begin
        if (load_start) begin
          state_d   = LOAD;
          tap_cnt_d = '0;
          err_d     = 1'b0;
        end else if (commit) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        // A strobe coincident with the commit was seen in ARMED, so this is
        // always the first strobe strictly after the commit.
        if (sample_stb) begin
          swap        = 1'b1;
          gen_d       = gen_q + 8'd1;
          flush_cnt_d = FLUSH_N;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        if (sample_stb) begin
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FCW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Error set takes priority over a clear in the same cycle.
    if (coef_valid && !ready_q) err_d = 1'b1;

    ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_cnt_q   <= '0;
      flush_cnt_q <= '0;
      gen_q       <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      gen_q       <= gen_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAP_LEN; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      if (shadow_we) shadow_q[tap_cnt_q] <= coef_data;
      if (swap) begin
        for (int unsigned i = 0; i < TAP_LEN; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  always_comb begin
    fir_coef = '0;
    for (int unsigned i = 0; i < TAP_LEN; i++) begin
      fir_coef[i*COEF_WIDTH +: COEF_WIDTH] = active_q[i];
    end
  end

  assign coef_ready = ready_q;
  assign flush      = (state_q == FLUSH);
  assign busy       = (state_q != IDLE);
  assign armed      = (state_q == ARMED) || (state_q == PENDING);
  assign coef_gen   = gen_q;
  assign err_unexp  = err_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
module tb_fir_coef_ctrl;

  localparam int TAP_LEN = 63;
  localparam int CW      = 16;
  localparam int FS      = 7;
  localparam int VW      = TAP_LEN * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_stb;
  logic          load_start;
  logic          coef_valid;
  logic [CW-1:0] coef_data;
  logic          coef_ready;
  logic          commit;
  logic [VW-1:0] fir_coef;
  logic          flush;
  logic          busy;
  logic          armed;
  logic [7:0]    coef_gen;
  logic          err_unexp;

  int n_checks = 0;
  int n_errors = 0;

  fir_coef_ctrl #(
    .TAP_LEN      (TAP_LEN),
    .COEF_WIDTH   (CW),
    .FLUSH_SAMPLES(FS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_stb(sample_stb),
    .load_start(load_start),
    .coef_valid(coef_valid),
    .coef_data (coef_data),
    .coef_ready(coef_ready),
    .commit    (commit),
    .fir_coef  (fir_coef),
    .flush     (flush),
    .busy      (busy),
    .armed     (armed),
    .coef_gen  (coef_gen),
    .err_unexp (err_unexp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] make_vec(input logic [CW-1:0] base, input bit incr);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < TAP_LEN; i++) v[i*CW +: CW] = incr ? base + CW'(i) : base;
    return v;
  endfunction

  function automatic logic [VW-1:0] passthru();
    logic [VW-1:0] v;
    v = '0;
    v[CW-1:0] = 16'h7FFF;
    return v;
  endfunction

  task automatic send_beats(input int n, input logic [CW-1:0] base, input bit incr, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          coef_valid = 1'b0;
          tick();
        end
      end
      coef_valid = 1'b1;
      coef_data  = incr ? base + CW'(i) : base;
      tick();
    end
    coef_valid = 1'b0;
  endtask

  task automatic pulse_load_start;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic strobe;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
  endtask

  task automatic drain_flush;
    repeat (FS) begin
      strobe();
      tick();
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sample_stb = 0; load_start = 0; coef_valid = 0; coef_data = '0; commit = 0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (fir_coef !== passthru()) begin n_errors++; $display("FAIL reset_fir_coef got %h exp %h", fir_coef, passthru()); end
    n_checks++; if ({flush, busy, armed, coef_ready, err_unexp} !== 5'b0) begin n_errors++; $display("FAIL reset_flags got %b exp 00000", {flush, busy, armed, coef_ready, err_unexp}); end
    n_checks++; if (coef_gen !== 8'd0) begin n_errors++; $display("FAIL reset_gen got %0d exp 0", coef_gen); end
  endtask

  task automatic test_load;
    pulse_load_start();
    n_checks++; if (coef_ready !== 1'b1) begin n_errors++; $display("FAIL load_ready_latency got %b exp 1", coef_ready); end
    send_beats(TAP_LEN, 16'd1, 1'b1, 1'b1);
    n_checks++; if ({armed, coef_ready, busy} !== 3'b101) begin n_errors++; $display("FAIL load_armed got %b exp 101", {armed, coef_ready, busy}); end
    n_checks++; if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL load_err got %b exp 0", err_unexp); end
    n_checks++; if (fir_coef !== passthru()) begin n_errors++; $display("FAIL load_active_kept got %h exp %h", fir_coef, passthru()); end
  endtask

  task automatic test_commit;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (4) tick();
    n_checks++; if (fir_coef !== passthru()) begin n_errors++; $display("FAIL commit_before_stb got %h exp %h", fir_coef, passthru()); end
    n_checks++; if (armed !== 1'b1) begin n_errors++; $display("FAIL commit_pending_armed got %b exp 1", armed); end
    strobe();
    n_checks++; if (fir_coef !== make_vec(16'd1, 1'b1)) begin n_errors++; $display("FAIL commit_swap got %h exp %h", fir_coef, make_vec(16'd1, 1'b1)); end
    n_checks++; if (coef_gen !== 8'd1) begin n_errors++; $display("FAIL commit_gen got %0d exp 1", coef_gen); end
    n_checks++; if ({flush, armed} !== 2'b10) begin n_errors++; $display("FAIL commit_flush_start got %b exp 10", {flush, armed}); end
    for (int k = 1; k <= FS; k++) begin
      tick();
      strobe();
      n_checks++; if (flush !== (k < FS)) begin n_errors++; $display("FAIL flush_strobe_%0d got %b exp %b", k, flush, (k < FS)); end
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL flush_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_same_cycle;
    pulse_load_start();
    send_beats(TAP_LEN, 16'd100, 1'b1, 1'b0);
    commit = 1'b1; sample_stb = 1'b1;
    tick();
    commit = 1'b0; sample_stb = 1'b0;
    n_checks++; if (fir_coef !== make_vec(16'd1, 1'b1)) begin n_errors++; $display("FAIL same_cycle_no_swap got %h exp %h", fir_coef, make_vec(16'd1, 1'b1)); end
    n_checks++; if (coef_gen !== 8'd1 || armed !== 1'b1) begin n_errors++; $display("FAIL same_cycle_gen got %0d/%b exp 1/1", coef_gen, armed); end
    tick();
    strobe();
    n_checks++; if (fir_coef !== make_vec(16'd100, 1'b1)) begin n_errors++; $display("FAIL same_cycle_swap got %h exp %h", fir_coef, make_vec(16'd100, 1'b1)); end
    n_checks++; if (coef_gen !== 8'd2) begin n_errors++; $display("FAIL same_cycle_gen2 got %0d exp 2", coef_gen); end
    drain_flush();
  endtask

  task automatic test_restart;
    pulse_load_start();
    send_beats(20, 16'd500, 1'b1, 1'b1);
    // Restart with a beat offered in the same cycle: the beat must be dropped.
    load_start = 1'b1; coef_valid = 1'b1; coef_data = 16'h1234;
    tick();
    load_start = 1'b0; coef_valid = 1'b0;
    send_beats(TAP_LEN, 16'h8000, 1'b0, 1'b1);
    n_checks++; if (armed !== 1'b1 || coef_ready !== 1'b0) begin n_errors++; $display("FAIL restart_armed got %b%b exp 10", armed, coef_ready); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    strobe();
    n_checks++; if (fir_coef !== make_vec(16'h8000, 1'b0)) begin n_errors++; $display("FAIL restart_swap got %h exp %h", fir_coef, make_vec(16'h8000, 1'b0)); end
    n_checks++; if (coef_gen !== 8'd3) begin n_errors++; $display("FAIL restart_gen got %0d exp 3", coef_gen); end
    drain_flush();
    coef_valid = 1'b1; coef_data = 16'h5555;
    tick();
    coef_valid = 1'b0;
    n_checks++; if (err_unexp !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL err_set got %b/%b exp 1/0", err_unexp, busy); end
    tick();
    n_checks++; if (err_unexp !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b exp 1", err_unexp); end
    pulse_load_start();
    n_checks++; if (err_unexp !== 1'b0 || coef_ready !== 1'b1) begin n_errors++; $display("FAIL err_clear got %b/%b exp 0/1", err_unexp, coef_ready); end
  endtask

  task automatic test_reset_mid;
    // Still in LOAD from the previous test.
    send_beats(10, 16'd7, 1'b1, 1'b0);
    do_reset();
    n_checks++; if (fir_coef !== passthru()) begin n_errors++; $display("FAIL rst_load_fir got %h exp %h", fir_coef, passthru()); end
    n_checks++; if ({busy, coef_ready, coef_gen} !== 10'd0) begin n_errors++; $display("FAIL rst_load_state got %b/%b/%0d exp 0/0/0", busy, coef_ready, coef_gen); end
    pulse_load_start();
    send_beats(TAP_LEN, 16'd40, 1'b1, 1'b0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    strobe();
    strobe();
    n_checks++; if (flush !== 1'b1 || coef_gen !== 8'd1) begin n_errors++; $display("FAIL rst_flush_pre got %b/%0d exp 1/1", flush, coef_gen); end
    do_reset();
    n_checks++; if (fir_coef !== passthru()) begin n_errors++; $display("FAIL rst_flush_fir got %h exp %h", fir_coef, passthru()); end
    n_checks++; if ({flush, busy, coef_gen} !== 10'd0) begin n_errors++; $display("FAIL rst_flush_state got %b/%b/%0d exp 0/0/0", flush, busy, coef_gen); end
  endtask

  task automatic test_gen_wrap;
    for (int g = 1; g <= 256; g++) begin
      pulse_load_start();
      send_beats(TAP_LEN, CW'(g), 1'b0, 1'b0);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      strobe();
      drain_flush();
      if (g == 255) begin
        n_checks++; if (coef_gen !== 8'd255) begin n_errors++; $display("FAIL gen_255 got %0d exp 255", coef_gen); end
      end
    end
    n_checks++; if (coef_gen !== 8'd0) begin n_errors++; $display("FAIL gen_wrap got %0d exp 0", coef_gen); end
    n_checks++; if (fir_coef !== make_vec(16'd256, 1'b0)) begin n_errors++; $display("FAIL gen_wrap_fir got %h exp %h", fir_coef, make_vec(16'd256, 1'b0)); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_commit();
    test_same_cycle();
    test_restart();
    test_reset_mid();
    test_gen_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
- Coefficient manager and sequencer for the pipelined direct-form FIR.
- Accepts a new coefficient set over a valid/ready stream into a shadow bank.
- Commits the set to the active bank only on a sample boundary, so the filter never sees a mixed set.
- Flags the filter output invalid while the pipeline flushes after each coefficient swap.

Parameters:
- TAP_LEN, 63, number of taps; width of the shadow and active banks.
- COEF_WIDTH, 16, signed Q15 coefficient width.
- FLUSH_SAMPLES, 7, number of sample strobes the filter needs to flush (1 multiply stage + ceil(log2(TAP_LEN)) adder stages).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sample_stb  in  1  one-cycle pulse per ADC sample; the same signal drives the filter clock enable.
- load_start  in  1  begins or restarts a coefficient load.
- coef_valid  in  1  stream valid.
- coef_data  in  COEF_WIDTH  signed coefficient; sent in order tap 0 to tap TAP_LEN-1.
- coef_ready  out  1  stream ready.
- commit  in  1  requests a swap of the shadow bank into the active bank.
- fir_coef  out  TAP_LEN*COEF_WIDTH  active bank, packed; tap i is at bits [i*COEF_WIDTH +: COEF_WIDTH].
- flush  out  1  high while the filter output is invalid after a swap.
- busy  out  1  high when state is not IDLE.
- armed  out  1  high when a complete set is in the shadow bank and waiting for commit (state ARMED or PENDING).
- coef_gen  out  8  swap counter; wraps from 255 to 0.
- err_unexp  out  1  sticky error: a beat arrived with coef_valid=1 while coef_ready=0.

Behaviour:
- Reset values:
  - State is IDLE; coef_ready, flush, busy, armed and err_unexp are 0; coef_gen is 0.
  - Active bank is the pass-through set: tap 0 = 16'h7FFF, all other taps 0.
  - Shadow bank is all 0; tap counter is 0.
  - A reset in any state, including mid-load or mid-flush, discards the partial load and restores these values on the next cycle.
- States: IDLE, LOAD, ARMED, PENDING, FLUSH.
- IDLE:
  - load_start=1 moves to LOAD, clears the tap counter and clears err_unexp.
  - commit is ignored.
- LOAD:
  - coef_ready=1, driven from a register.
  - A beat transfers when coef_valid and coef_ready are both 1; the beat writes shadow[tap_cnt] and tap_cnt increments.
  - After the beat with tap_cnt=TAP_LEN-1: go to ARMED, and coef_ready is 0 from the next cycle.
  - load_start=1 during LOAD resets tap_cnt to 0 and the state stays LOAD; if a beat transfers in the same cycle, the beat is dropped.
  - Shadow taps not yet rewritten keep their old values.
- ARMED:
  - commit=1 moves to PENDING.
  - load_start=1 moves to LOAD with tap_cnt=0 (reload).
  - If commit and load_start are both 1, load_start wins.
- PENDING:
  - On the first sample_stb, all taps of the active bank are loaded from shadow in parallel; fir_coef changes on the next cycle.
  - In the same cycle, coef_gen increments and the state moves to FLUSH with flush_cnt=FLUSH_SAMPLES.
  - commit and sample_stb arriving together in ARMED do not swap; the swap happens at the next sample_stb.
  - load_start is ignored in PENDING and FLUSH.
- FLUSH:
  - flush=1 from the cycle after the swap.
  - Each sample_stb decrements flush_cnt.
  - The strobe that takes flush_cnt from 1 to 0 moves the state to IDLE; flush drops on the next cycle.
  - Exactly FLUSH_SAMPLES strobes are counted.
- Error flag: err_unexp is set whenever coef_valid=1 and coef_ready=0; the beat is discarded, and the flag is cleared only by load_start or reset.
- Shadow bank is kept after a commit; a commit without a new load cannot occur, because commit is only accepted in ARMED.
- Latencies:
  - load_start to coef_ready=1: 1 cycle.
  - Commit to swap: the first sample_stb strictly after the commit cycle.
- No arithmetic on coefficient values; they pass through bit-exact.

Test Plan:
- Reset, then read fir_coef -> tap0=16'h7FFF, taps 1..62 = 0; flush=0, busy=0, coef_gen=0.
- Load taps 0..62 with values i+1, with random valid gaps -> exactly 63 transfers, armed=1, coef_ready=0; fir_coef still the pass-through set.
- Commit, then sample_stb 5 cycles later -> fir_coef equals 1..63 one cycle after the strobe; coef_gen=1; flush=1 for exactly 7 strobes, then 0.
- Commit and sample_stb in the same cycle -> no swap on that strobe; swap on the next strobe.
- Load 20 beats, pulse load_start, then load 63 beats of 16'h8000 -> after commit, all taps = 16'h8000 (no leftovers from the first 20 beats); a coef_valid pulse while in IDLE sets err_unexp, and load_start clears it.
- Assert rst during FLUSH and during LOAD -> pass-through set restored, state IDLE, coef_gen=0; 256 commit cycles -> coef_gen wraps to 0.
